cpu_run_controller: RTL
=======================

Name: cpu_run_controller

Overview:
- Sequences the Hack CPU core by driving its `hold` and `reset` inputs.
- Accepts run, halt, step-N and reset commands over a valid/ready interface. Sources are the debug UART front-end or board buttons.
- Stops the core on a PC breakpoint and counts executed instruction cycles.
- Sits between the debug command decoder and the CPU; it has no view of instruction memory or data memory.

Parameters:
- RESET_CYCLES, 2, cycles `cpu_reset` is held high per CPU reset (1..255).
- AUTORUN, 0, if 1, leave CPU reset in RUNNING instead of HALTED.
- STEP_WIDTH, 16, width of the step-count argument.

Ports:
- clock  input  1  system clock
- reset  input  1  controller reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when valid&ready
- cmd_op  input  2  0=HALT, 1=RUN, 2=STEP, 3=CPU_RESET
- cmd_arg  input  STEP_WIDTH  step count for STEP
- bp_enable  input  1  breakpoint armed
- bp_addr  input  15  breakpoint PC
- cpu_pc  input  15  CPU pc output
- cpu_hold  output  1  to CPU hold
- cpu_reset  output  1  to CPU reset
- state  output  2  0=RESET_CPU, 1=HALTED, 2=RUNNING, 3=STEPPING
- stop_event  output  1  one-cycle pulse on entry to HALTED from RUNNING/STEPPING
- stop_cause  output  2  0=command, 1=breakpoint, 2=step done; held until next stop
- cycle_count  output  32  executed CPU cycles, saturating

Behaviour:
Interface:
- Reset is `reset`, synchronous, active-high; clock is `clock`.

Reset values:
- On `reset`: state=RESET_CPU, reset counter=RESET_CYCLES, cpu_reset=1, cpu_hold=1.
- stop_event=0, stop_cause=0, cycle_count=0, step counter=0, skip_bp=0.

Execution:
- A CPU cycle "executes" in any cycle where cpu_hold=0 and cpu_reset=0.
- Both `cpu_hold` and `cpu_reset` are combinational from registered state, plus the breakpoint compare.

Signal definitions:
- `cpu_reset` = (state==RESET_CPU).
- `cpu_hold` = 1 in RESET_CPU and HALTED. In RUNNING/STEPPING, `cpu_hold` = bp_hit.
- bp_hit = bp_enable & (cpu_pc==bp_addr) & ~skip_bp.
- A breakpoint therefore stops the core before the instruction at bp_addr executes.

skip_bp:
- Set on every transition HALTED→RUNNING or HALTED→STEPPING.
- Cleared after the first executed cycle. This lets the core resume from a breakpoint address.

cmd_ready:
- 0 in RESET_CPU, 1 otherwise.
- Commands are consumed on valid&ready. Unsupported combinations are consumed and ignored.

RESET_CPU:
- Counter decrements each cycle.
- When counter==1: next state is RUNNING if AUTORUN, else HALTED. Also clear cycle_count and skip_bp.
- No stop_event is raised on this exit.

HALTED:
- RUN → RUNNING.
- STEP with arg≠0 → STEPPING, step counter=arg.
- STEP with arg=0 → stay HALTED, no event.
- HALT → no-op.

RUNNING:
- HALT → HALTED, cause 0. The instruction in the accept cycle still executes unless bp_hit.
- bp_hit → HALTED, cause 1.
- RUN and STEP are ignored.

STEPPING:
- Each executed cycle decrements the step counter.
- Executed cycle with counter==1 → HALTED, cause 2.
- bp_hit → HALTED, cause 1.
- HALT → HALTED, cause 0.

CPU_RESET:
- Accepted in any non-RESET_CPU state.
- → RESET_CPU with counter=RESET_CYCLES; overrides everything else.
- No stop_event.

Priority in a single cycle:
- CPU_RESET command > bp_hit > HALT command > step done.
- stop_cause reports the highest-priority cause.

stop_event:
- Registered pulse, asserted the cycle state first reads HALTED.

cycle_count:
- +1 per executed cycle; saturates at 0xFFFFFFFF.
- Cleared only by reset and the RESET_CPU exit.

Mid-operation reset:
- `reset` asserted mid-run or mid-step returns the controller to RESET_CPU immediately.
- Pending step count is discarded.

Test Plan:
- Reset with AUTORUN=0, RESET_CYCLES=2 → cpu_reset high exactly 2 cycles, then state=HALTED, cpu_hold=1, cycle_count=0, cmd_ready=1.
- STEP arg=5 from HALTED, bp_enable=0 → cpu_hold low exactly 5 cycles; cycle_count=5; stop_event once; stop_cause=2; state=HALTED.
- RUN with bp_enable=1, bp_addr=0x0004, CPU counting from pc 0 → executes pcs 0..3, hold asserted while cpu_pc=4, stop_cause=1. A second RUN executes pc 4 (skip_bp) and continues.
- RUN, then HALT after 10 executed cycles → cycle_count=11 (accept cycle executes), stop_cause=0. STEP arg=0 afterwards → no change, no stop_event.
- STEP arg=3 when the breakpoint matches the 2nd instruction → stops after 1 executed cycle, stop_cause=1 (breakpoint beats step done).
- Mid-STEP CPU_RESET command → RESET_CPU next cycle, cpu_reset high RESET_CYCLES cycles, no stop_event, cycle_count=0. Also check `reset` asserted while RUNNING yields the reset values above.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Run/halt/step sequencer for the Hack CPU core: drives cpu_hold/cpu_reset from
// debug commands, stops on a PC breakpoint and counts executed instruction cycles.
module cpu_run_controller #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter bit          AUTORUN      = 1'b0,
    parameter int unsigned STEP_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [STEP_WIDTH-1:0] cmd_arg,
    input  logic                  bp_enable,
    input  logic [14:0]           bp_addr,
    input  logic [14:0]           cpu_pc,
    output logic                  cpu_hold,
    output logic                  cpu_reset,
    output logic [1:0]            state,
    output logic                  stop_event,
    output logic [1:0]            stop_cause,
    output logic [31:0]           cycle_count
);

    typedef enum logic [1:0] {
        S_RESET_CPU = 2'd0,
        S_HALTED    = 2'd1,
        S_RUNNING   = 2'd2,
        S_STEPPING  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_HALT      = 2'd0,
        OP_RUN       = 2'd1,
        OP_STEP      = 2'd2,
        OP_CPU_RESET = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        CAUSE_CMD  = 2'd0,
        CAUSE_BP   = 2'd1,
        CAUSE_STEP = 2'd2
    } cause_e;

    state_e                state_q, state_d;
    logic [7:0]            rst_cnt_q, rst_cnt_d;
    logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic                  skip_bp_q, skip_bp_d;
    logic                  stop_event_q, stop_event_d;
    cause_e                stop_cause_q, stop_cause_d;
    logic [31:0]           cycle_count_q, cycle_count_d;

    logic active;
    logic bp_hit;
    logic exec;
    logic accept;
    op_e  op;

    assign op        = op_e'(cmd_op);
    assign active    = (state_q == S_RUNNING) || (state_q == S_STEPPING);
    assign bp_hit    = bp_enable && (cpu_pc == bp_addr) && !skip_bp_q;
    assign cpu_reset = (state_q == S_RESET_CPU);
    assign cpu_hold  = active ? bp_hit : 1'b1;
    assign exec      = !cpu_hold && !cpu_reset;
    assign cmd_ready = (state_q != S_RESET_CPU);
    assign accept    = cmd_valid && cmd_ready;

    assign state       = state_q;
    assign stop_event  = stop_event_q;
    assign stop_cause  = stop_cause_q;
    assign cycle_count = cycle_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_RESET_CPU;
            rst_cnt_q     <= 8'(RESET_CYCLES);
            step_cnt_q    <= '0;
            skip_bp_q     <= 1'b0;
            stop_event_q  <= 1'b0;
            stop_cause_q  <= CAUSE_CMD;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            step_cnt_q    <= step_cnt_d;
            skip_bp_q     <= skip_bp_d;
            stop_event_q  <= stop_event_d;
            stop_cause_q  <= stop_cause_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        step_cnt_d    = step_cnt_q;
        skip_bp_d     = skip_bp_q;
        stop_event_d  = 1'b0;
        stop_cause_d  = stop_cause_q;
        cycle_count_d = cycle_count_q;

        if (exec) begin
            skip_bp_d = 1'b0;
            if (cycle_count_q != '1) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end
        end

        unique case (state_q)
            S_RESET_CPU: begin
                rst_cnt_d = rst_cnt_q - 8'd1;
                if (rst_cnt_q <= 8'd1) begin
                    state_d       = AUTORUN ? S_RUNNING : S_HALTED;
                    cycle_count_d = '0;
                    skip_bp_d     = 1'b0;
                end
            end
            S_HALTED: begin
                if (accept && op == OP_RUN) begin
                    state_d   = S_RUNNING;
                    skip_bp_d = 1'b1;
                end else if (accept && op == OP_STEP && cmd_arg != '0) begin
                    state_d    = S_STEPPING;
                    step_cnt_d = cmd_arg;
                    skip_bp_d  = 1'b1;
                end
            end
            S_RUNNING: begin
                if (bp_hit) begin
                    state_d      = S_HALTED;
                    stop_event_d = 1'b1;
                    stop_cause_d = CAUSE_BP;
                end else if (accept && op == OP_HALT) begin
                    state_d      = S_HALTED;
                    stop_event_d = 1'b1;
                    stop_cause_d = CAUSE_CMD;
                end
            end
            S_STEPPING: begin
                if (exec) begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
                if (bp_hit) begin
                    state_d      = S_HALTED;
                    stop_event_d = 1'b1;
                    stop_cause_d = CAUSE_BP;
                end else if (accept && op == OP_HALT) begin
                    state_d      = S_HALTED;
                    stop_event_d = 1'b1;
                    stop_cause_d = CAUSE_CMD;
                end else if (exec && step_cnt_q == STEP_WIDTH'(1)) begin
                    state_d      = S_HALTED;
                    stop_event_d = 1'b1;
                    stop_cause_d = CAUSE_STEP;
                end
            end
            default: state_d = S_RESET_CPU;
        endcase

        // CPU_RESET wins over any stop decided above and raises no event
        if (accept && op == OP_CPU_RESET) begin
            state_d      = S_RESET_CPU;
            rst_cnt_d    = 8'(RESET_CYCLES);
            step_cnt_d   = '0;
            stop_event_d = 1'b0;
            stop_cause_d = stop_cause_q;
        end
    end

endmodule
